// File: rtl/max_reduce_ctrl.sv
// Streaming signed-max reducer: returns max, first index of max, count-1 and truncation flag per vector.
// Latency: result valid on the edge after the last element; backpressure holds the result and stalls input.
module max_reduce_ctrl #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0]        out_idx,
    output logic [IDX_W-1:0]        out_count,
    output logic                    out_trunc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [WIDTH-1:0] acc;
    logic [IDX_W-1:0]        best_idx;
    logic [IDX_W-1:0]        cnt;
    logic                    trunc;
    logic                    accept;
    logic [IDX_W-1:0]        cnt_inc;
    logic                    cnt_full;

    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + 1'b1;
    // Vector is force-closed once its index field can hold no further element.
    assign cnt_full = (cnt_inc == {IDX_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && (in_last || cnt_full)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake signals depend on state alone so no comb path crosses the block.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            best_idx <= '0;
            cnt      <= '0;
            trunc    <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc      <= in_data;
                best_idx <= '0;
                cnt      <= '0;
                trunc    <= 1'b0;
            end else begin
                cnt   <= cnt_inc;
                trunc <= cnt_full && !in_last;
                // Strict compare keeps the earliest index on ties.
                if (in_data > acc) begin
                    acc      <= in_data;
                    best_idx <= cnt_inc;
                end
            end
        end
    end

    assign out_max   = acc;
    assign out_idx   = best_idx;
    assign out_count = cnt;
    assign out_trunc = trunc;

endmodule

// File: tb/tb_max_reduce_ctrl.sv
// Randomized and directed checks of max_reduce_ctrl against a queue-based reference model.
module tb_max_reduce_ctrl;
    localparam int W    = 16;
    localparam int IW   = 4;
    localparam int MAXN = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_max;
    logic [IW-1:0]       out_idx;
    logic [IW-1:0]       out_count;
    logic                out_trunc;

    int n_cmp = 0;
    int n_bad = 0;
    int seg[$];

    always #5 clk = ~clk;

    max_reduce_ctrl #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_max",   out_max,   0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_count", out_count, 0);
        check("rst_out_trunc", out_trunc, 0);
    endtask

    // Reference: max over the closed segment, first index wins ties.
    task automatic result(input int hold, input logic last);
        int   mx;
        int   mi;
        logic tr;
        mx = seg[0];
        mi = 0;
        foreach (seg[i]) begin
            if (seg[i] > mx) begin
                mx = seg[i];
                mi = i;
            end
        end
        tr = (seg.size() == MAXN) && !last;
        check("out_valid_rise", out_valid, 1);
        check("out_max",   out_max,   mx);
        check("out_idx",   out_idx,   mi);
        check("out_count", out_count, seg.size() - 1);
        check("out_trunc", out_trunc, tr);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("hold_in_ready",  in_ready,  0);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_max",   out_max,   mx);
            check("hold_out_idx",   out_idx,   mi);
            check("hold_out_count", out_count, seg.size() - 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_fall", out_valid, 0);
        check("idle_in_ready",  in_ready,  1);
        seg.delete();
    endtask

    task automatic push(input int d, input logic l, input int gap, input int hold);
        logic              r;
        int                budget;
        logic signed [W-1:0] v;
        v        = d[W-1:0];
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        in_last  = l;
        r        = 1'b0;
        budget   = 0;
        while (!r && budget < 40) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        if (!r) begin
            check("accept_timeout", 0, 1);
            return;
        end
        seg.push_back(int'(v));
        if (l || seg.size() == MAXN) begin
            result(hold, l);
        end else begin
            check("accum_out_valid", out_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ex[4];
        int tv[5];
        ex = '{-32768, 32767, -1, 0};
        tv = '{5, -3, 9, 9, 2};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) push(tv[i], i == 4, 0, 0);
        push(-32768, 1'b1, 0, 0);
        push(-1, 1'b0, 0, 0);
        push(-32768, 1'b0, 0, 0);
        push(-2, 1'b1, 0, 0);
        for (int i = 0; i < 16; i++) push(i, 1'b0, 0, 0);
        push(3, 1'b1, 0, 10);
        for (int i = 0; i < 5; i++) push(tv[i], i == 4, $urandom_range(0, 4), 0);

        for (int i = 0; i < 3; i++) push(tv[i], 1'b0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seg.delete();
        push(7, 1'b1, 0, 0);

        for (int v = 0; v < 40; v++) begin
            int len;
            int mode;
            len  = $urandom_range(1, 20);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) begin
                int val;
                logic l;
                if (mode == 0)      val = int'($urandom_range(0, 3)) - 2;
                else if (mode == 1) val = int'($urandom_range(0, 65535)) - 32768;
                else                val = ex[$urandom_range(0, 3)];
                l = (i == len - 1) && ($urandom_range(0, 4) != 0);
                push(val, l, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                     $urandom_range(0, 3));
            end
        end
        if (seg.size() != 0) push(1, 1'b1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
